// File: rtl/coprocessor_seq_pkg.sv
// Package: coprocessor_seq_pkg
// Shared definitions for the coprocessor command sequencer: the sequencer
// state encoding, the Avalon register map and the STAT bit positions.
package coprocessor_seq_pkg;

    localparam int OP_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_e;

    localparam logic [1:0] ADDR_CMD  = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_TMO  = 2'd2;
    localparam logic [1:0] ADDR_IEN  = 2'd3;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_DONE       = 1;
    localparam int STAT_TIMEOUT    = 2;
    localparam int STAT_OVERFLOW   = 3;
    localparam int STAT_COUNT_LSB  = 4;
    localparam int STAT_COUNT_W    = 3;
    localparam int STAT_LASTOP_LSB = 8;

endpackage

// File: rtl/cop_cmd_fifo.sv
// Module: cop_cmd_fifo
// Small synchronous FIFO holding queued coprocessor opcodes. A push while
// full and a pop while empty are ignored; a push and a pop in the same cycle
// are both performed. DEPTH must be a power of two so the pointers wrap.
module cop_cmd_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy count advance on accepted push/pop.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/coprocessor_cmd_sequencer.sv
// Module: coprocessor_cmd_sequencer
// Avalon-MM slave that queues opcodes from the Nios and hands them to the
// coprocessor one at a time: a one-cycle start pulse per opcode, then a wait
// for done or a programmable timeout. Sticky status bits are polled via STAT.
// Optional feature macro: COP_SEQ_IRQ_EN adds the IEN register and a level
// interrupt; without it irq is held low and address 3 reads as zero.
module coprocessor_cmd_sequencer
    import coprocessor_seq_pkg::*;
#(
    parameter int                OP_W       = OP_W_DEF,
    parameter int                FIFO_DEPTH = 4,
    parameter int                TMO_W      = 16,
    parameter logic [TMO_W-1:0]  TMO_RST    = {TMO_W{1'b1}}
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic [OP_W-1:0] cop_op,
    output logic            cop_start,
    input  logic            cop_done,
    output logic            irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

    seq_state_e       state_q;
    logic [OP_W-1:0]  cop_op_q;
    logic             cop_start_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             overflow_q, overflow_d;
    logic [OP_W-1:0]  last_op_q, last_op_d;

    logic             bus_wr, cmd_wr, stat_wr, tmo_wr;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [OP_W-1:0]  fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             done_set, timeout_set, overflow_set;
    logic [31:0]      stat_word;
    logic             unused_wdata;

    assign bus_wr  = chipselect & ~write_n;
    assign cmd_wr  = bus_wr & (address == ADDR_CMD);
    assign stat_wr = bus_wr & (address == ADDR_STAT);
    assign tmo_wr  = bus_wr & (address == ADDR_TMO);

    assign fifo_pop     = (state_q == ST_IDLE) & ~fifo_empty;
    assign done_set     = (state_q == ST_WAIT) & cop_done;
    assign timeout_set  = (state_q == ST_WAIT) & ~cop_done & (tmo_q != '0)
                          & (tmo_cnt_q == (tmo_q - TMO_ONE));
    assign overflow_set = cmd_wr & fifo_full;

    assign unused_wdata = ^writedata[31:TMO_W];

    cop_cmd_fifo #(
        .W     (OP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .push_i   (cmd_wr),
        .data_i   (writedata[OP_W-1:0]),
        .pop_i    (fifo_pop),
        .data_o   (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    // Sticky status next-state: software write-1-to-clear first, hardware set overrides.
    always_comb begin
        done_d     = done_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;
        last_op_d  = last_op_q;
        tmo_d      = tmo_q;
        if (stat_wr) begin
            if (writedata[STAT_DONE])     done_d     = 1'b0;
            if (writedata[STAT_TIMEOUT])  timeout_d  = 1'b0;
            if (writedata[STAT_OVERFLOW]) overflow_d = 1'b0;
        end
        if (done_set) begin
            done_d    = 1'b1;
            last_op_d = cop_op_q;
        end
        if (timeout_set)  timeout_d  = 1'b1;
        if (overflow_set) overflow_d = 1'b1;
        if (tmo_wr)       tmo_d      = writedata[TMO_W-1:0];
    end

    // Status and timeout-limit registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            last_op_q  <= '0;
            tmo_q      <= TMO_RST;
        end else begin
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
            last_op_q  <= last_op_d;
            tmo_q      <= tmo_d;
        end
    end

    // Issue FSM: pop in IDLE, pulse start in ISSUE, wait for done or timeout in WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cop_op_q    <= '0;
            cop_start_q <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            cop_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cop_op_q    <= fifo_head;
                        cop_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt_q <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tmo_cnt_q != TMO_MAX) begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
                    end
                    if (done_set || timeout_set) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cop_op    = cop_op_q;
    assign cop_start = cop_start_q;

    // Assemble the STAT word from live state and sticky bits.
    always_comb begin
        stat_word = '0;
        stat_word[STAT_BUSY]     = (state_q != ST_IDLE) | ~fifo_empty;
        stat_word[STAT_DONE]     = done_q;
        stat_word[STAT_TIMEOUT]  = timeout_q;
        stat_word[STAT_OVERFLOW] = overflow_q;
        stat_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
        stat_word[STAT_LASTOP_LSB +: OP_W]        = last_op_q;
    end

`ifdef COP_SEQ_IRQ_EN
    logic       ien_wr;
    logic [2:0] ien_q, ien_d;
    logic       irq_q;

    assign ien_wr = bus_wr & (address == ADDR_IEN);
    assign ien_d  = ien_wr ? writedata[2:0] : ien_q;

    // Interrupt enables and a registered level interrupt aligned with STAT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ien_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ien_q <= ien_d;
            irq_q <= |(ien_d & {overflow_d, timeout_d, done_d});
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CMD:  readdata = '0;
            ADDR_STAT: readdata = stat_word;
            ADDR_TMO:  readdata[TMO_W-1:0] = tmo_q;
`ifdef COP_SEQ_IRQ_EN
            ADDR_IEN:  readdata[2:0] = ien_q;
`else
            ADDR_IEN:  readdata = '0;
`endif
            default:   readdata = '0;
        endcase
    end

endmodule
